axi_inf_burst_scheduler: RTL and testbench
==========================================

Name: axi_inf_burst_scheduler

Overview:
Shares one axi_inf_write_state_core (or read core) between NCH DMA channels.
- Accepts per-channel transfer commands (start address, total beats).
- Splits each command into AXI bursts of at most MAX_BURST beats.
- Round-robins bursts between active channels and drives the core's req/len/addr interface.
- Tracks per-burst completion and error from the core's done/pend outputs.
- Sits between the VDMA channel front-ends and the AXI state core; grant[] steers the data mux.

Parameters:
NCH, 2, number of requesting channels (2..8)
ASIZE, 32, address width
LSIZE, 10, core length width; MAX_BURST < 2**LSIZE
TSIZE, 24, command total-length width in beats
MAX_BURST, 64, maximum beats per burst (1..256)
BEAT_LOG2, 5, log2 bytes per beat (32-byte beats, matches awsize 3'b101)

Ports:
axi_aclk  in  1  clock
axi_resetn  in  1  asynchronous active-low reset
cmd_valid  in  NCH  per-channel command valid
cmd_ready  out  NCH  per-channel command ready
cmd_addr  in  NCH*ASIZE  packed start byte address, beat aligned; channel i at [i*ASIZE +: ASIZE]
cmd_len  in  NCH*TSIZE  packed total beats
cmd_done  out  NCH  one-cycle pulse when a channel's command completes
cmd_err  out  NCH  one-cycle pulse with cmd_done if any burst of that command failed
busy  out  1  any channel active or burst in flight
grant  out  NCH  one-hot, channel owning the current burst; 0 when none
core_req  out  1  to core write_req/read_req
core_len  out  LSIZE  burst beats, to core req_len
core_addr  out  ASIZE  burst byte address, to core req_addr
core_resp  in  1  core req_resp
core_done  in  1  core req_done
core_pend  in  1  core pend_out

Behaviour:
Reset:
- Async on axi_resetn low, regardless of state: FSM to ARB; all channel state cleared.
- All outputs 0 except cmd_ready = all ones.

Per-channel registers: active, addr[ASIZE], remain[TSIZE], err.
- cmd_ready[i] = ~active[i], registered-derived.
- Handshake on cmd_valid[i] & cmd_ready[i] at cycle T:
  - if cmd_len != 0: addr and remain loaded, active = 1 at T+1.
  - if cmd_len == 0: cmd_done[i] pulses at T+1, no burst issued, active stays 0.

FSM states: ARB, ISSUE, WAIT_DONE, UPDATE.
- ARB:
  - if any active: pick the first active channel searching from last_grant+1 with wrap (round robin; after reset search starts at 0).
  - Register grant, core_addr = addr, core_len = blen. Next: ISSUE.
  - Otherwise stay in ARB.
- ISSUE: core_req = 1, held until core_resp is sampled 1; core_req = 0 next cycle, then WAIT_DONE. Core PEND waits are absorbed here.
- WAIT_DONE: completion is the falling edge of core_pend (pend_d = 1, core_pend = 0). The burst failed if core_done = 0 in that cycle (core BERR path). Next: UPDATE.
- UPDATE (one cycle), for the granted channel:
  - addr += blen << BEAT_LOG2; remain -= blen; err |= fail.
  - If remain becomes 0: cmd_done pulses, cmd_err pulses = err, active and err clear.
  - grant = 0. Next: ARB.

Burst length and timing:
- blen = min(remain, MAX_BURST, beats to 4 KB boundary when AXI4K_SPLIT_EN). blen is never 0 for an active channel.
- Latency: handshake at T gives core_req high at T+2 (ARB at T+1) when idle.
- Burst to burst: 1 cycle UPDATE + 1 cycle ARB.

Simultaneous events:
- New commands are accepted in any FSM state.
- A command arriving during another channel's burst joins the next arbitration.
- A channel that completes in UPDATE may accept a new command in the same cycle cmd_ready rises; it becomes eligible on the following ARB.
- Address arithmetic wraps modulo 2**ASIZE with no error.

Optional Feature:
AXI4K_SPLIT_EN:
- Defined: blen is also capped at (4096 - addr[11:0]) >> BEAT_LOG2, so no burst crosses a 4 KB boundary.
- Undefined: cap is min(remain, MAX_BURST) only; the channel front-end must guarantee boundaries.

Test Plan:
- Ch0 cmd addr 0x1000, len 150, core responds OKAY -> three bursts (addr, len) = (0x1000, 64), (0x1800, 64), (0x2000, 22); cmd_done[0] one pulse, cmd_err 0.
- Ch0 len 128 and ch1 len 128 issued together -> bursts alternate ch0, ch1, ch0, ch1; grant one-hot matches each burst; both done.
- AXI4K_SPLIT_EN, addr 0x0FC0, len 10 -> bursts (0x0FC0, 2) then (0x1000, 8); without the macro -> a single (0x0FC0, 10).
- Second burst ends with core_pend falling while core_done = 0 -> remaining bursts still issued; final cmd_done with cmd_err = 1.
- cmd_len 0 on ch1 -> cmd_done[1] at T+1, core_req never asserted.
- axi_resetn low during WAIT_DONE -> core_req, grant, busy, cmd_done go 0 immediately (async); after release a new cmd runs normally.

Source files
------------

// File: rtl/axi_inf_burst_scheduler_if.sv
// Command and core-request bundle between the DMA channel front-ends, the burst scheduler and the AXI state core.
// The master modport is the scheduler side; the slave modport is the front-end/core side.
interface axi_inf_burst_scheduler_if #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned ASIZE = 32,
    parameter int unsigned LSIZE = 10,
    parameter int unsigned TSIZE = 24
);
    logic [NCH-1:0]       cmd_valid;
    logic [NCH-1:0]       cmd_ready;
    logic [NCH*ASIZE-1:0] cmd_addr;
    logic [NCH*TSIZE-1:0] cmd_len;
    logic [NCH-1:0]       cmd_done;
    logic [NCH-1:0]       cmd_err;
    logic                 busy;
    logic [NCH-1:0]       grant;
    logic                 core_req;
    logic [LSIZE-1:0]     core_len;
    logic [ASIZE-1:0]     core_addr;
    logic                 core_resp;
    logic                 core_done;
    logic                 core_pend;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, core_resp, core_done, core_pend,
        output cmd_ready, cmd_done, cmd_err, busy, grant, core_req, core_len, core_addr
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, core_resp, core_done, core_pend,
        input  cmd_ready, cmd_done, cmd_err, busy, grant, core_req, core_len, core_addr
    );
endinterface

// File: rtl/axi_inf_burst_scheduler.sv
// Splits per-channel DMA commands into AXI bursts and round-robins them onto one shared AXI state core.
// Define AXI4K_SPLIT_EN to additionally cap every burst at the next 4 KB boundary.
module axi_inf_burst_scheduler #(
    parameter int unsigned NCH       = 2,
    parameter int unsigned ASIZE     = 32,
    parameter int unsigned LSIZE     = 10,
    parameter int unsigned TSIZE     = 24,
    parameter int unsigned MAX_BURST = 64,
    parameter int unsigned BEAT_LOG2 = 5
) (
    input  logic                        axi_aclk,
    input  logic                        axi_resetn,
    axi_inf_burst_scheduler_if.master   bus
);
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {ARB = 2'd0, ISSUE = 2'd1, WAIT_DONE = 2'd2, UPDATE = 2'd3} state_t;

    state_t           state, state_nxt;
    logic [NCH-1:0]   active, active_n, err, err_n;
    logic [ASIZE-1:0] addr [NCH];
    logic [ASIZE-1:0] addr_n [NCH];
    logic [TSIZE-1:0] remain [NCH];
    logic [TSIZE-1:0] remain_n [NCH];
    logic [CW-1:0]    last_gnt, last_n, gidx, gidx_n, pick;
    logic             pend_d, burst_fail, fail_n, any_active;
    logic [NCH-1:0]   grant_q, grant_n, done_q, done_n, errp_q, errp_n;
    logic             core_req_q, req_n;
    logic [LSIZE-1:0] core_len_q, len_n, blen;
    logic [ASIZE-1:0] core_addr_q, caddr_n, addr_sel, upd_addr;
    logic [TSIZE-1:0] rem_sel, upd_rem;
    logic [12:0]      blen_w;
    int unsigned      idx;
`ifdef AXI4K_SPLIT_EN
    logic [12:0]      beats_4k;
`endif

    assign any_active    = |active;
    assign bus.cmd_ready = ~active;
    assign bus.busy      = any_active | (state != ARB);
    assign bus.grant     = grant_q;
    assign bus.cmd_done  = done_q;
    assign bus.cmd_err   = errp_q;
    assign bus.core_req  = core_req_q;
    assign bus.core_len  = core_len_q;
    assign bus.core_addr = core_addr_q;

    // Round robin: first active channel searching from last_gnt+1 with wrap
    always_comb begin
        pick = '0;
        idx  = 0;
        for (int unsigned k = NCH; k > 0; k--) begin
            idx = 32'(last_gnt) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (active[CW'(idx)]) pick = CW'(idx);
        end
    end

    // Burst length for the picked channel
    always_comb begin
        rem_sel  = remain[pick];
        addr_sel = addr[pick];
        blen_w   = 13'(MAX_BURST);
        if (rem_sel < TSIZE'(MAX_BURST)) blen_w = 13'(rem_sel);
`ifdef AXI4K_SPLIT_EN
        beats_4k = 13'((13'd4096 - {1'b0, addr_sel[11:0]}) >> BEAT_LOG2);
        if (beats_4k < blen_w) blen_w = beats_4k;
`endif
        blen = LSIZE'(blen_w);
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) state <= ARB;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:       if (any_active) state_nxt = ISSUE;
            ISSUE:     if (bus.core_resp) state_nxt = WAIT_DONE;
            WAIT_DONE: if (pend_d && !bus.core_pend) state_nxt = UPDATE;
            UPDATE:    state_nxt = ARB;
            default:   state_nxt = ARB;
        endcase
    end

    // Next values of channel state and registered outputs
    always_comb begin
        active_n = active;
        err_n    = err;
        addr_n   = addr;
        remain_n = remain;
        grant_n  = grant_q;
        gidx_n   = gidx;
        last_n   = last_gnt;
        done_n   = '0;
        errp_n   = '0;
        req_n    = core_req_q;
        len_n    = core_len_q;
        caddr_n  = core_addr_q;
        fail_n   = burst_fail;
        upd_addr = addr[gidx] + (ASIZE'(core_len_q) << BEAT_LOG2);
        upd_rem  = remain[gidx] - TSIZE'(core_len_q);

        for (int i = 0; i < NCH; i++) begin
            if (bus.cmd_valid[i] && !active[i]) begin
                if (bus.cmd_len[i*TSIZE +: TSIZE] != '0) begin
                    active_n[i] = 1'b1;
                    addr_n[i]   = bus.cmd_addr[i*ASIZE +: ASIZE];
                    remain_n[i] = bus.cmd_len[i*TSIZE +: TSIZE];
                end else begin
                    done_n[i] = 1'b1;
                end
            end
        end

        case (state)
            ARB: if (any_active) begin
                grant_n = NCH'(1) << pick;
                gidx_n  = pick;
                last_n  = pick;
                req_n   = 1'b1;
                len_n   = blen;
                caddr_n = addr_sel;
                fail_n  = 1'b0;
            end
            ISSUE:     if (bus.core_resp) req_n = 1'b0;
            WAIT_DONE: if (pend_d && !bus.core_pend) fail_n = !bus.core_done;
            UPDATE: begin
                addr_n[gidx]   = upd_addr;
                remain_n[gidx] = upd_rem;
                grant_n        = '0;
                if (upd_rem == '0) begin
                    done_n[gidx]   = 1'b1;
                    errp_n[gidx]   = err[gidx] | burst_fail;
                    active_n[gidx] = 1'b0;
                    err_n[gidx]    = 1'b0;
                end else begin
                    err_n[gidx] = err[gidx] | burst_fail;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            active      <= '0;
            err         <= '0;
            for (int i = 0; i < NCH; i++) begin
                addr[i]   <= '0;
                remain[i] <= '0;
            end
            last_gnt    <= CW'(NCH - 1);
            gidx        <= '0;
            pend_d      <= 1'b0;
            burst_fail  <= 1'b0;
            grant_q     <= '0;
            done_q      <= '0;
            errp_q      <= '0;
            core_req_q  <= 1'b0;
            core_len_q  <= '0;
            core_addr_q <= '0;
        end else begin
            active      <= active_n;
            err         <= err_n;
            addr        <= addr_n;
            remain      <= remain_n;
            last_gnt    <= last_n;
            gidx        <= gidx_n;
            pend_d      <= bus.core_pend;
            burst_fail  <= fail_n;
            grant_q     <= grant_n;
            done_q      <= done_n;
            errp_q      <= errp_n;
            core_req_q  <= req_n;
            core_len_q  <= len_n;
            core_addr_q <= caddr_n;
        end
    end
endmodule

// File: tb/tb_axi_inf_burst_scheduler.sv
// Self-checking bench for axi_inf_burst_scheduler: a behavioural core answers each burst, a scoreboard
// holds expected (grant, addr, len) bursts and (done, err) pulses.
module tb_axi_inf_burst_scheduler;
    typedef struct packed {
        logic [1:0]  grant;
        logic [31:0] addr;
        logic [9:0]  len;
    } burst_t;

    typedef struct packed {
        logic [1:0] done;
        logic [1:0] err;
    } done_t;

    logic axi_aclk;
    logic axi_resetn;

    axi_inf_burst_scheduler_if #(.NCH(2), .ASIZE(32), .LSIZE(10), .TSIZE(24)) bif ();

    axi_inf_burst_scheduler #(
        .NCH(2), .ASIZE(32), .LSIZE(10), .TSIZE(24), .MAX_BURST(64), .BEAT_LOG2(5)
    ) dut (
        .axi_aclk   (axi_aclk),
        .axi_resetn (axi_resetn),
        .bus        (bif)
    );

    int     checks     = 0;
    int     failures   = 0;
    int     core_phase = 0;
    int     pend_cnt   = 0;
    int     burst_cnt  = 0;
    int     fail_at    = -1;
    burst_t exp_q[$];
    burst_t obs_q[$];
    done_t  exp_done[$];
    done_t  obs_done[$];

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    // Behavioural core: resp one cycle after req, pend for three cycles, done unless the burst is marked failing
    initial begin : core_model
        burst_t b;
        bif.core_resp = 1'b0;
        bif.core_pend = 1'b0;
        bif.core_done = 1'b0;
        forever begin
            @(posedge axi_aclk); #1;
            bif.core_done = 1'b0;
            if (!axi_resetn) begin
                bif.core_resp = 1'b0;
                bif.core_pend = 1'b0;
                core_phase    = 0;
            end else begin
                case (core_phase)
                    0: if (bif.core_req === 1'b1) begin
                        b = '{grant: bif.grant, addr: bif.core_addr, len: bif.core_len};
                        obs_q.push_back(b);
                        bif.core_resp = 1'b1;
                        core_phase    = 1;
                    end
                    1: begin
                        bif.core_resp = 1'b0;
                        bif.core_pend = 1'b1;
                        pend_cnt      = 2;
                        core_phase    = 2;
                    end
                    2: if (pend_cnt == 0) begin
                        bif.core_pend = 1'b0;
                        bif.core_done = (burst_cnt != fail_at);
                        burst_cnt++;
                        core_phase = 0;
                    end else begin
                        pend_cnt--;
                    end
                    default: core_phase = 0;
                endcase
            end
        end
    end

    initial begin : done_monitor
        done_t d;
        forever begin
            @(negedge axi_aclk);
            if ((bif.cmd_done | bif.cmd_err) !== 2'b00) begin
                d = '{done: bif.cmd_done, err: bif.cmd_err};
                obs_done.push_back(d);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        axi_resetn    = 1'b0;
        bif.cmd_valid = '0;
        bif.cmd_addr  = '0;
        bif.cmd_len   = '0;
        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        axi_resetn = 1'b1;
        obs_q.delete();
        obs_done.delete();
    endtask

    // Returns #1 after the handshake edge
    task automatic send_cmd(input int ch, input logic [31:0] a, input logic [23:0] n);
        @(negedge axi_aclk);
        bif.cmd_valid[ch]         = 1'b1;
        bif.cmd_addr[ch*32 +: 32] = a;
        bif.cmd_len[ch*24 +: 24]  = n;
        @(posedge axi_aclk); #1;
        bif.cmd_valid[ch] = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] g, input logic [31:0] a, input logic [9:0] l);
        burst_t b;
        b = '{grant: g, addr: a, len: l};
        exp_q.push_back(b);
    endtask

    task automatic push_done(input logic [1:0] d, input logic [1:0] e);
        done_t x;
        x = '{done: d, err: e};
        exp_done.push_back(x);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((bif.busy !== 1'b0 || core_phase != 0) && n < 3000) begin
            @(posedge axi_aclk); #1;
            n++;
        end
        repeat (2) @(posedge axi_aclk);
        #1;
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL %s_timeout busy=%b after %0d cycles, required idle", tag, bif.busy, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge axi_aclk); #1;
        checks += 6;
        if (bif.cmd_ready !== 2'b11) begin failures++; $display("FAIL rst_ready got %b exp 11", bif.cmd_ready); end
        if (bif.grant !== 2'b00)     begin failures++; $display("FAIL rst_grant got %b exp 00", bif.grant); end
        if (bif.busy !== 1'b0)       begin failures++; $display("FAIL rst_busy got %b exp 0", bif.busy); end
        if (bif.core_req !== 1'b0)   begin failures++; $display("FAIL rst_req got %b exp 0", bif.core_req); end
        if (bif.cmd_done !== 2'b00 || bif.cmd_err !== 2'b00) begin
            failures++; $display("FAIL rst_done got %b/%b exp 00/00", bif.cmd_done, bif.cmd_err);
        end
        if (bif.core_len !== 10'd0 || bif.core_addr !== 32'd0) begin
            failures++; $display("FAIL rst_core got len=%0d addr=%h exp 0/0", bif.core_len, bif.core_addr);
        end
    endtask

    task automatic test_split();
        burst_t e, o;
        done_t  de, dob;
        push_exp(2'b01, 32'h1000, 10'd64);
        push_exp(2'b01, 32'h1800, 10'd64);
        push_exp(2'b01, 32'h2000, 10'd22);
        push_done(2'b01, 2'b00);
        send_cmd(0, 32'h1000, 24'd150);
        checks++;
        if (bif.core_req !== 1'b0) begin failures++; $display("FAIL split_arb_req got %b exp 0", bif.core_req); end
        @(posedge axi_aclk); #1;
        checks++;
        if (bif.core_req !== 1'b1 || bif.grant !== 2'b01) begin
            failures++; $display("FAIL split_latency got req=%b grant=%b exp 1/01", bif.core_req, bif.grant);
        end
        wait_idle("split");
        checks++;
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL split_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL split_burst got g=%b a=%h l=%0d exp g=%b a=%h l=%0d", o.grant, o.addr, o.len, e.grant, e.addr, e.len); end
        end
        checks++;
        if (obs_done.size() != exp_done.size()) begin failures++; $display("FAIL split_done_count got %0d exp %0d", obs_done.size(), exp_done.size()); end
        while (exp_done.size() > 0 && obs_done.size() > 0) begin
            de = exp_done.pop_front(); dob = obs_done.pop_front(); checks++;
            if (dob !== de) begin failures++; $display("FAIL split_done got %b/%b exp %b/%b", dob.done, dob.err, de.done, de.err); end
        end
        exp_q.delete(); obs_q.delete(); exp_done.delete(); obs_done.delete();
    endtask

    task automatic test_two_channels();
        burst_t e, o;
        done_t  de, dob;
        do_reset();
        push_exp(2'b01, 32'h0000_0000, 10'd64);
        push_exp(2'b10, 32'h0001_0000, 10'd64);
        push_exp(2'b01, 32'h0000_0800, 10'd64);
        push_exp(2'b10, 32'h0001_0800, 10'd64);
        push_done(2'b01, 2'b00);
        push_done(2'b10, 2'b00);
        @(negedge axi_aclk);
        bif.cmd_valid = 2'b11;
        bif.cmd_addr  = {32'h0001_0000, 32'h0000_0000};
        bif.cmd_len   = {24'd128, 24'd128};
        @(posedge axi_aclk); #1;
        bif.cmd_valid = 2'b00;
        wait_idle("two_ch");
        checks++;
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL two_ch_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL two_ch_burst got g=%b a=%h l=%0d exp g=%b a=%h l=%0d", o.grant, o.addr, o.len, e.grant, e.addr, e.len); end
        end
        checks++;
        if (obs_done.size() != exp_done.size()) begin failures++; $display("FAIL two_ch_done_count got %0d exp %0d", obs_done.size(), exp_done.size()); end
        while (exp_done.size() > 0 && obs_done.size() > 0) begin
            de = exp_done.pop_front(); dob = obs_done.pop_front(); checks++;
            if (dob !== de) begin failures++; $display("FAIL two_ch_done got %b/%b exp %b/%b", dob.done, dob.err, de.done, de.err); end
        end
        exp_q.delete(); obs_q.delete(); exp_done.delete(); obs_done.delete();
    endtask

    task automatic test_4k_boundary();
        burst_t e, o;
`ifdef AXI4K_SPLIT_EN
        push_exp(2'b01, 32'h0FC0, 10'd2);
        push_exp(2'b01, 32'h1000, 10'd8);
`else
        push_exp(2'b01, 32'h0FC0, 10'd10);
`endif
        send_cmd(0, 32'h0FC0, 24'd10);
        wait_idle("4k");
        checks++;
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL 4k_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL 4k_burst got g=%b a=%h l=%0d exp g=%b a=%h l=%0d", o.grant, o.addr, o.len, e.grant, e.addr, e.len); end
        end
        exp_q.delete(); obs_q.delete(); obs_done.delete();
    endtask

    task automatic test_burst_error();
        burst_t e, o;
        done_t  de, dob;
        push_exp(2'b10, 32'h4000, 10'd64);
        push_exp(2'b10, 32'h4800, 10'd64);
        push_exp(2'b10, 32'h5000, 10'd64);
        push_exp(2'b10, 32'h5800, 10'd8);
        push_done(2'b10, 2'b10);
        fail_at = burst_cnt + 1;
        send_cmd(1, 32'h4000, 24'd200);
        wait_idle("err");
        fail_at = -1;
        // error flag must not leak into the next command
        push_exp(2'b10, 32'h6000, 10'd5);
        push_done(2'b10, 2'b00);
        send_cmd(1, 32'h6000, 24'd5);
        wait_idle("err_next");
        checks++;
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL err_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL err_burst got g=%b a=%h l=%0d exp g=%b a=%h l=%0d", o.grant, o.addr, o.len, e.grant, e.addr, e.len); end
        end
        checks++;
        if (obs_done.size() != exp_done.size()) begin failures++; $display("FAIL err_done_count got %0d exp %0d", obs_done.size(), exp_done.size()); end
        while (exp_done.size() > 0 && obs_done.size() > 0) begin
            de = exp_done.pop_front(); dob = obs_done.pop_front(); checks++;
            if (dob !== de) begin failures++; $display("FAIL err_done got %b/%b exp %b/%b", dob.done, dob.err, de.done, de.err); end
        end
        exp_q.delete(); obs_q.delete(); exp_done.delete(); obs_done.delete();
    endtask

    task automatic test_zero_len();
        int req_seen = 0;
        int busy_seen = 0;
        send_cmd(1, 32'h7000, 24'd0);
        checks++;
        if (bif.cmd_done !== 2'b10 || bif.cmd_err !== 2'b00) begin
            failures++; $display("FAIL zero_done got %b/%b exp 10/00", bif.cmd_done, bif.cmd_err);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge axi_aclk); #1;
            if (bif.core_req !== 1'b0) req_seen++;
            if (bif.busy !== 1'b0) busy_seen++;
            if (i == 0) begin
                checks++;
                if (bif.cmd_done !== 2'b00) begin failures++; $display("FAIL zero_pulse got %b exp 00", bif.cmd_done); end
            end
        end
        checks += 2;
        if (req_seen != 0)  begin failures++; $display("FAIL zero_req got %0d req cycles exp 0", req_seen); end
        if (busy_seen != 0) begin failures++; $display("FAIL zero_busy got %0d busy cycles exp 0", busy_seen); end
        obs_q.delete(); obs_done.delete();
    endtask

    task automatic test_back_to_back();
        burst_t e, o;
        done_t  de, dob;
        int n = 0;
        push_exp(2'b01, 32'h8000, 10'd64);
        push_exp(2'b01, 32'h9000, 10'd32);
        push_done(2'b01, 2'b00);
        push_done(2'b01, 2'b00);
        send_cmd(0, 32'h8000, 24'd64);
        while (bif.cmd_ready[0] !== 1'b1 && n < 2000) begin @(posedge axi_aclk); #1; n++; end
        checks++;
        if (n >= 2000) begin failures++; $display("FAIL b2b_ready_timeout ready=%b exp 1", bif.cmd_ready[0]); end
        bif.cmd_valid[0]   = 1'b1;
        bif.cmd_addr[31:0] = 32'h9000;
        bif.cmd_len[23:0]  = 24'd32;
        @(posedge axi_aclk); #1;
        bif.cmd_valid[0] = 1'b0;
        wait_idle("b2b");
        checks++;
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL b2b_burst got g=%b a=%h l=%0d exp g=%b a=%h l=%0d", o.grant, o.addr, o.len, e.grant, e.addr, e.len); end
        end
        checks++;
        if (obs_done.size() != exp_done.size()) begin failures++; $display("FAIL b2b_done_count got %0d exp %0d", obs_done.size(), exp_done.size()); end
        while (exp_done.size() > 0 && obs_done.size() > 0) begin
            de = exp_done.pop_front(); dob = obs_done.pop_front(); checks++;
            if (dob !== de) begin failures++; $display("FAIL b2b_done got %b/%b exp %b/%b", dob.done, dob.err, de.done, de.err); end
        end
        exp_q.delete(); obs_q.delete(); exp_done.delete(); obs_done.delete();
    endtask

    task automatic test_reset_mid_burst();
        burst_t e, o;
        done_t  de, dob;
        int n = 0;
        send_cmd(0, 32'h3000, 24'd64);
        while (bif.core_pend !== 1'b1 && n < 100) begin @(posedge axi_aclk); #1; n++; end
        checks++;
        if (n >= 100) begin failures++; $display("FAIL rmid_pend_timeout pend=%b exp 1", bif.core_pend); end
        #2;
        axi_resetn = 1'b0;
        #1;
        checks += 4;
        if (bif.core_req !== 1'b0 || bif.grant !== 2'b00) begin
            failures++; $display("FAIL rmid_req_grant got %b/%b exp 0/00", bif.core_req, bif.grant);
        end
        if (bif.busy !== 1'b0)       begin failures++; $display("FAIL rmid_busy got %b exp 0", bif.busy); end
        if (bif.cmd_done !== 2'b00)  begin failures++; $display("FAIL rmid_done got %b exp 00", bif.cmd_done); end
        if (bif.cmd_ready !== 2'b11) begin failures++; $display("FAIL rmid_ready got %b exp 11", bif.cmd_ready); end
        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        axi_resetn = 1'b1;
        obs_q.delete(); obs_done.delete();
        push_exp(2'b01, 32'h5000, 10'd64);
        push_exp(2'b01, 32'h5800, 10'd6);
        push_done(2'b01, 2'b00);
        send_cmd(0, 32'h5000, 24'd70);
        wait_idle("rmid");
        checks++;
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rmid_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL rmid_burst got g=%b a=%h l=%0d exp g=%b a=%h l=%0d", o.grant, o.addr, o.len, e.grant, e.addr, e.len); end
        end
        checks++;
        if (obs_done.size() != exp_done.size()) begin failures++; $display("FAIL rmid_done_count got %0d exp %0d", obs_done.size(), exp_done.size()); end
        while (exp_done.size() > 0 && obs_done.size() > 0) begin
            de = exp_done.pop_front(); dob = obs_done.pop_front(); checks++;
            if (dob !== de) begin failures++; $display("FAIL rmid_done got %b/%b exp %b/%b", dob.done, dob.err, de.done, de.err); end
        end
        exp_q.delete(); obs_q.delete(); exp_done.delete(); obs_done.delete();
    endtask

    initial begin : main
        test_reset();
        test_split();
        test_two_channels();
        test_4k_boundary();
        test_burst_error();
        test_zero_len();
        test_back_to_back();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
